// File: rtl/bilstm_pkg.sv
// Constants and loader state type shared by the BiLSTM input path.
// input_memory address arithmetic uses the same constants.
package bilstm_pkg;
  localparam int DATA_WIDTH          = 16;
  localparam int INPUTS_PER_TIMESTEP = 6;
  localparam int SEQ_LEN             = 10;
  localparam int MEM_DEPTH           = SEQ_LEN * INPUTS_PER_TIMESTEP;
  localparam int ADDR_WIDTH          = $clog2(MEM_DEPTH);

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    FULL = 1'b1
  } loader_state_t;
endpackage

// File: rtl/input_index_counter.sv
// Element/timestep index pair for input_memory writes.
// The address is step*INPUTS_PER_TIMESTEP + elem.
module input_index_counter #(
  parameter int SEQ_LEN             = bilstm_pkg::SEQ_LEN,
  parameter int INPUTS_PER_TIMESTEP = bilstm_pkg::INPUTS_PER_TIMESTEP,
  parameter int ADDR_WIDTH          = bilstm_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_advance,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_wrap,
  output logic                  o_final
);
  import bilstm_pkg::*;

  localparam int ELEM_W = (INPUTS_PER_TIMESTEP > 1) ? $clog2(INPUTS_PER_TIMESTEP) : 1;
  localparam int STEP_W = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  logic [ELEM_W-1:0] r_elem;
  logic [STEP_W-1:0] r_step;

  assign o_wrap  = (r_elem == ELEM_W'(INPUTS_PER_TIMESTEP - 1));
  assign o_final = o_wrap && (r_step == STEP_W'(SEQ_LEN - 1));
  assign o_addr  = ADDR_WIDTH'(r_step) * ADDR_WIDTH'(INPUTS_PER_TIMESTEP) + ADDR_WIDTH'(r_elem);

  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_elem <= '0;
      r_step <= '0;
    end else if (i_advance) begin
      if (o_wrap) begin
        r_elem <= '0;
        r_step <= r_step + STEP_W'(1);
      end else begin
        r_elem <= r_elem + ELEM_W'(1);
      end
    end
  end
endmodule

// File: rtl/input_loader.sv
// Write-side feeder for input_memory: streams samples in order, reports
// readable timesteps and holds the frame until the BiLSTM releases it.
//
// state | meaning
// LOAD  | accepting samples (s_ready=1)
// FULL  | frame complete, waiting for frame_release (s_ready=0)
module input_loader #(
  parameter int DATA_WIDTH          = bilstm_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH          = bilstm_pkg::ADDR_WIDTH,
  parameter int SEQ_LEN             = bilstm_pkg::SEQ_LEN,
  parameter int INPUTS_PER_TIMESTEP = bilstm_pkg::INPUTS_PER_TIMESTEP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  input  logic                  frame_release,
  input  logic                  flush,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [3:0]            steps_loaded,
  output logic                  frame_ready,
  output logic                  frame_error
);
  import bilstm_pkg::*;

  loader_state_t         r_state;
  loader_state_t         w_next_state;
  logic                  r_s_ready;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [3:0]            r_steps;
  logic                  r_frame_ready;
  logic                  r_frame_error;
  logic                  r_wrap_d;
  logic                  r_final_d;

  logic                  w_accept;
  logic                  w_beat;
  logic                  w_wrap;
  logic                  w_final;
  logic                  w_early_last;
  logic                  w_release;
  logic                  w_clear;
  logic [ADDR_WIDTH-1:0] w_addr;

  // A beat accepted together with flush is consumed but never written.
  assign w_accept     = s_valid && r_s_ready;
  assign w_beat       = w_accept && !flush;
  assign w_early_last = w_beat && s_last && !w_final;
  assign w_release    = frame_release && !flush && (r_state == FULL);
  assign w_clear      = flush || w_release || w_early_last || (w_beat && w_final);

  input_index_counter #(
    .SEQ_LEN            (SEQ_LEN),
    .INPUTS_PER_TIMESTEP(INPUTS_PER_TIMESTEP),
    .ADDR_WIDTH         (ADDR_WIDTH)
  ) u_index (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_advance(w_beat),
    .o_addr   (w_addr),
    .o_wrap   (w_wrap),
    .o_final  (w_final)
  );

  always_comb begin
    w_next_state = r_state;
    if (flush || w_release) begin
      w_next_state = LOAD;
    end else if (w_beat && w_final) begin
      w_next_state = FULL;
    end
  end

  // Step/frame status lags the write by one more cycle so it only
  // advertises data that input_memory has already captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= LOAD;
      r_s_ready     <= 1'b0;
      r_we          <= 1'b0;
      r_addr        <= '0;
      r_data        <= '0;
      r_steps       <= '0;
      r_frame_ready <= 1'b0;
      r_frame_error <= 1'b0;
      r_wrap_d      <= 1'b0;
      r_final_d     <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_s_ready <= (w_next_state == LOAD);
      r_we      <= w_beat;
      if (w_beat) begin
        r_addr <= w_addr;
        r_data <= s_data;
      end
      r_wrap_d  <= w_beat && w_wrap && !w_early_last;
      r_final_d <= w_beat && w_final;

      if (flush || w_release || w_early_last) begin
        r_steps <= '0;
      end else if (r_wrap_d) begin
        r_steps <= r_steps + 4'd1;
      end

      if (flush || w_release) begin
        r_frame_ready <= 1'b0;
      end else if (r_final_d) begin
        r_frame_ready <= 1'b1;
      end

      if (flush) begin
        r_frame_error <= 1'b0;
      end else if (w_early_last || (w_beat && w_final && !s_last)) begin
        r_frame_error <= 1'b1;
      end
    end
  end

  assign s_ready       = r_s_ready;
  assign write_enable  = r_we;
  assign write_address = r_addr;
  assign write_data    = r_data;
  assign steps_loaded  = r_steps;
  assign frame_ready   = r_frame_ready;
  assign frame_error   = r_frame_error;
endmodule

// File: tb/tb_input_loader.sv
// Bench for input_loader: frame-level model checked every cycle plus
// directed frames with hand-computed expectations.
module tb_input_loader;
  localparam int DEPTH = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        frame_release = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] s_data = '0;
  logic        s_ready;
  logic        write_enable;
  logic [5:0]  write_address;
  logic [15:0] write_data;
  logic [3:0]  steps_loaded;
  logic        frame_ready;
  logic        frame_error;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  input_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .frame_release(frame_release),
    .flush        (flush),
    .write_enable (write_enable),
    .write_address(write_address),
    .write_data   (write_data),
    .steps_loaded (steps_loaded),
    .frame_ready  (frame_ready),
    .frame_error  (frame_error)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame-level model: beats counted per frame, status changes scheduled by cycle.
  logic        m_ready, m_full, m_we, m_fr, m_err;
  logic        m_acc, m_beat, m_fin, m_early, m_drop;
  logic [5:0]  m_addr;
  logic [15:0] m_data;
  int          m_count, m_steps, m_fr_due;
  int          m_due[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      m_ready = 0; m_full = 0; m_we = 0; m_addr = '0; m_data = '0;
      m_count = 0; m_steps = 0; m_fr = 0; m_err = 0; m_fr_due = -1;
      m_due.delete();
    end else begin
      m_acc   = s_valid && m_ready;
      m_beat  = m_acc && !flush;
      m_fin   = m_beat && (m_count == DEPTH - 1);
      m_early = m_beat && s_last && !m_fin;
      m_drop  = flush || (m_full && frame_release);
      m_we    = m_beat;
      if (m_beat) begin
        m_addr = 6'(m_count);
        m_data = s_data;
      end
      if (m_drop || m_early) begin
        m_steps = 0;
        m_due.delete();
      end else begin
        while (m_due.size() > 0 && m_due[0] == cyc) begin
          m_steps++;
          void'(m_due.pop_front());
        end
      end
      if (m_beat && (m_count % 6 == 5) && !m_early) m_due.push_back(cyc + 1);
      if (m_drop) begin
        m_fr = 0; m_fr_due = -1;
      end else if (m_fr_due == cyc) begin
        m_fr = 1; m_fr_due = -1;
      end
      if (m_fin) m_fr_due = cyc + 1;
      if (flush) m_err = 0;
      else if (m_early || (m_fin && !s_last)) m_err = 1;
      if (m_drop) begin
        m_full = 0; m_count = 0;
      end else if (m_fin) begin
        m_full = 1; m_count = 0;
      end else if (m_early) begin
        m_count = 0;
      end else if (m_beat) begin
        m_count++;
      end
      m_ready = !m_full;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("s_ready", int'(s_ready), int'(m_ready));
      chk("write_enable", int'(write_enable), int'(m_we));
      chk("write_address", int'(write_address), int'(m_addr));
      chk("write_data", int'(write_data), int'(m_data));
      chk("steps_loaded", int'(steps_loaded), m_steps);
      chk("frame_ready", int'(frame_ready), int'(m_fr));
      chk("frame_error", int'(frame_error), int'(m_err));
    end
  end

  // Record what the DUT wrote, for literal checks.
  logic signed [15:0] wr_mem [DEPTH];
  int wr_cnt, last_addr, first_addr, first_fr;
  int first_step [11];
  int acc_cyc [DEPTH];

  always @(negedge clk) begin
    if (write_enable) begin
      wr_mem[write_address] = write_data;
      wr_cnt++;
      last_addr = int'(write_address);
      if (first_addr < 0) first_addr = int'(write_address);
    end
    if (steps_loaded <= 4'd10 && first_step[steps_loaded] < 0) first_step[steps_loaded] = cyc;
    if (frame_ready && first_fr < 0) first_fr = cyc;
  end

  task automatic clear_tracking();
    wr_cnt = 0; last_addr = -1; first_addr = -1; first_fr = -1;
    for (int i = 0; i < 11; i++) first_step[i] = -1;
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic beat(input int d, input logic last, input int gap, input logic fl, output int acc_c);
    int   tmo;
    logic rdy;
    tmo = 0;
    rdy = 1'b0;
    acc_c = -1;
    s_valid = 1'b0;
    step(gap);
    s_valid = 1'b1; s_data = 16'(d); s_last = last; flush = fl;
    do begin
      @(negedge clk);
      rdy = s_ready;
      acc_c = cyc;
      @(posedge clk); #1;
      tmo++;
    end while (!rdy && tmo < 50);
    if (!rdy) chk("accept_timeout", 0, 1);
    s_valid = 1'b0; s_last = 1'b0; flush = 1'b0;
  endtask

  task automatic frame(input int n, input int last_at, input int gapmax, input int flush_at);
    int c;
    for (int i = 0; i < n; i++) begin
      beat(i - 30, (i == last_at), (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0,
           (i == flush_at), c);
      acc_cyc[i] = c;
    end
  endtask

  task automatic pulse(input logic rel, input logic fl);
    frame_release = rel; flush = fl;
    step(1);
    frame_release = 1'b0; flush = 1'b0;
  endtask

  initial begin
    clear_tracking();
    // reset
    step(3);
    chk("rst_s_ready", int'(s_ready), 0);
    chk("rst_we", int'(write_enable), 0);
    chk("rst_addr", int'(write_address), 0);
    chk("rst_data", int'(write_data), 0);
    chk("rst_steps", int'(steps_loaded), 0);
    chk("rst_frame_ready", int'(frame_ready), 0);
    chk("rst_frame_error", int'(frame_error), 0);
    rst_n = 1'b1;
    chk("ready_before_edge", int'(s_ready), 0);
    step(1);
    chk("ready_after_release", int'(s_ready), 1);

    // full frame, no gaps
    clear_tracking();
    frame(60, 59, 0, -1);
    step(3);
    chk("a_wr_cnt", wr_cnt, 60);
    chk("a_wr0", int'(wr_mem[0]), -30);
    chk("a_wr33", int'(wr_mem[33]), 3);
    chk("a_wr59", int'(wr_mem[59]), 29);
    chk("a_step1_lag", first_step[1] - acc_cyc[5], 2);
    chk("a_step10_lag", first_step[10] - acc_cyc[59], 2);
    chk("a_frame_ready_lag", first_fr - acc_cyc[59], 2);
    chk("a_frame_ready", int'(frame_ready), 1);
    chk("a_frame_error", int'(frame_error), 0);
    chk("a_steps", int'(steps_loaded), 10);
    chk("a_full_not_ready", int'(s_ready), 0);

    // gapped frame after release
    pulse(1'b1, 1'b0);
    clear_tracking();
    frame(60, 59, 2, -1);
    step(3);
    chk("b_wr_cnt", wr_cnt, 60);
    chk("b_first_addr", first_addr, 0);
    chk("b_wr0", int'(wr_mem[0]), -30);
    chk("b_wr59", int'(wr_mem[59]), 29);
    chk("b_frame_ready", int'(frame_ready), 1);
    s_valid = 1'b1; s_data = 16'h1234;
    step(4);
    s_valid = 1'b0;
    chk("b_no_write_past_end", wr_cnt, 60);

    // early s_last on beat 20
    pulse(1'b1, 1'b0);
    clear_tracking();
    frame(21, 20, 0, -1);
    step(3);
    chk("c_frame_error", int'(frame_error), 1);
    chk("c_steps", int'(steps_loaded), 0);
    chk("c_ready", int'(s_ready), 1);
    pulse(1'b1, 1'b0);
    clear_tracking();
    frame(60, -1, 0, -1);
    step(3);
    chk("c_first_addr", first_addr, 0);
    chk("c_wr_cnt", wr_cnt, 60);
    chk("c_frame_ready", int'(frame_ready), 1);
    chk("c_frame_error_kept", int'(frame_error), 1);

    // flush coincident with beat 33
    pulse(1'b1, 1'b0);
    clear_tracking();
    frame(34, -1, 0, 33);
    step(3);
    chk("d_wr_cnt", wr_cnt, 33);
    chk("d_last_addr", last_addr, 32);
    chk("d_frame_error", int'(frame_error), 0);
    chk("d_steps", int'(steps_loaded), 0);
    clear_tracking();
    frame(60, 59, 0, -1);
    step(3);
    chk("d_first_addr", first_addr, 0);
    chk("d_frame_ready", int'(frame_ready), 1);

    // flush and release together in FULL
    pulse(1'b1, 1'b1);
    step(1);
    chk("e_ready", int'(s_ready), 1);
    chk("e_frame_ready", int'(frame_ready), 0);
    chk("e_steps", int'(steps_loaded), 0);

    // reset at beat 40
    clear_tracking();
    frame(40, -1, 0, -1);
    s_valid = 1'b1; s_data = 16'd10; rst_n = 1'b0;
    step(1);
    s_valid = 1'b0;
    chk("f_rst_we", int'(write_enable), 0);
    chk("f_rst_ready", int'(s_ready), 0);
    chk("f_rst_addr", int'(write_address), 0);
    step(1);
    rst_n = 1'b1;
    chk("f_wr_cnt", wr_cnt, 40);
    step(1);
    clear_tracking();
    frame(1, -1, 0, -1);
    step(2);
    chk("f_first_addr", first_addr, 0);
    chk("f_wr_cnt_after", wr_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    chk("global_timeout", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
